bank_cmd_scheduler: RTL and testbench

//  Per-bank command sequencer for one DDR bank (bank_group/bank already decoded upstream).

---
 rtl/bank_cmd_scheduler_pkg.sv | 43 ++++
 rtl/bank_cmd_scheduler_if.sv | 26 ++
 rtl/ddr_bank_timer.sv | 20 ++
 rtl/bank_cmd_scheduler.sv | 157 +++++++++++++++
 tb/tb_bank_cmd_scheduler.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/bank_cmd_scheduler_pkg.sv
// Shared types and timing defaults for the per-bank DDR command scheduler.
package bank_cmd_scheduler_pkg;

  localparam int unsigned T_RCD_DEF        = 4;
  localparam int unsigned T_RP_DEF         = 4;
  localparam int unsigned T_RAS_DEF        = 8;
  localparam int unsigned T_CCD_DEF        = 2;
  localparam int unsigned IDLE_TIMEOUT_DEF = 16;

  typedef enum logic {
    REQ_READ  = 1'b0,
    REQ_WRITE = 1'b1
  } req_type_t;

  typedef struct packed {
    req_type_t   req_type;
    logic [31:0] data;
    logic [15:0] row;
    logic [9:0]  column;
  } opt_request_t;

  typedef enum logic [2:0] {
    CMD_NONE      = 3'd0,
    CMD_ACTIVATE  = 3'd1,
    CMD_READ      = 3'd2,
    CMD_WRITE     = 3'd3,
    CMD_PRECHARGE = 3'd4
  } command_t;

  typedef enum logic [1:0] {
    CLOSED,
    ACT_WAIT,
    OPEN,
    PRE_WAIT
  } bank_state_t;

  // Timer reload value: counter must reach zero 'cycles' after the handshake,
  // minus the cycles already absorbed by the registered state transition.
  function automatic logic [7:0] timer_load(input int unsigned cycles, input int unsigned skew);
    return (cycles > skew) ? 8'(cycles - skew) : 8'd0;
  endfunction

endpackage

// File: rtl/bank_cmd_scheduler_if.sv
// Request-queue and command-arbiter handshake bundle for one bank scheduler.
interface bank_cmd_scheduler_if import bank_cmd_scheduler_pkg::*; ();

  logic         req_valid;
  opt_request_t req;
  logic         req_ready;
  logic         cmd_valid;
  logic         cmd_ready;
  command_t     cmd;
  logic [15:0]  cmd_row;
  logic [9:0]   cmd_col;
  logic [31:0]  cmd_data;
  logic         row_open;
  logic [15:0]  open_row;

  modport slave (
    input  req_valid, req, cmd_ready,
    output req_ready, cmd_valid, cmd, cmd_row, cmd_col, cmd_data, row_open, open_row
  );

  modport master (
    output req_valid, req, cmd_ready,
    input  req_ready, cmd_valid, cmd, cmd_row, cmd_col, cmd_data, row_open, open_row
  );

endinterface

// File: rtl/ddr_bank_timer.sv
// Loadable 8-bit down counter that saturates at zero and flags expiry.
module ddr_bank_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       zero
);

  logic [7:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                count <= '0;
    else if (load)          count <= load_val;
    else if (count != '0)   count <= count - 8'd1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/bank_cmd_scheduler.sv
// Open-page command sequencer for one DDR bank honouring tRCD/tRP/tRAS/tCCD.
// Optional idle auto-precharge is enabled by defining BANK_IDLE_PRE_EN.
module bank_cmd_scheduler import bank_cmd_scheduler_pkg::*; #(
  parameter int unsigned T_RCD        = T_RCD_DEF,
  parameter int unsigned T_RP         = T_RP_DEF,
  parameter int unsigned T_RAS        = T_RAS_DEF,
  parameter int unsigned T_CCD        = T_CCD_DEF,
  parameter int unsigned IDLE_TIMEOUT = IDLE_TIMEOUT_DEF
) (
  input logic                 clk,
  input logic                 rst,
  bank_cmd_scheduler_if.slave bus
);

  if (T_RCD == 0 || T_RCD > 255 || T_RP == 0 || T_RP > 255 || T_RAS == 0 || T_RAS > 255 ||
      T_CCD == 0 || T_CCD > 255 || IDLE_TIMEOUT == 0 || IDLE_TIMEOUT > 255) begin : g_param_check
    $error("bank_cmd_scheduler: timing parameters must lie in 1..255");
  end

  // Wait states cost one cycle of their own, hence the extra skew on tRCD/tRP.
  localparam logic [7:0] RCD_LOAD = timer_load(T_RCD, 2);
  localparam logic [7:0] RP_LOAD  = timer_load(T_RP, 2);
  localparam logic [7:0] RAS_LOAD = timer_load(T_RAS, 1);
  localparam logic [7:0] CCD_LOAD = timer_load(T_CCD, 1);

  bank_state_t  state, state_nxt;
  opt_request_t rq;
  logic         row_open_q;
  logic [15:0]  open_row_q;
  logic         offer, fire, idle_pre;
  command_t     cmd_c;
  logic [15:0]  row_c;
  logic [9:0]   col_c;
  logic [31:0]  data_c;
  logic         wait_zero, ras_zero, ccd_zero;
  logic         is_col;

  assign rq = bus.req;

  always_comb begin
    state_nxt = state;
    offer     = 1'b0;
    cmd_c     = CMD_NONE;
    row_c     = '0;
    col_c     = '0;
    data_c    = '0;
    if (!rst) begin
      case (state)
        CLOSED: if (bus.req_valid) begin
          offer = 1'b1;
          cmd_c = CMD_ACTIVATE;
          row_c = rq.row;
        end
        ACT_WAIT: if (wait_zero) state_nxt = OPEN;
        OPEN: begin
          if (idle_pre) begin
            offer = 1'b1;
            cmd_c = CMD_PRECHARGE;
          end else if (bus.req_valid && rq.row == open_row_q) begin
            if (ccd_zero) begin
              offer  = 1'b1;
              cmd_c  = (rq.req_type == REQ_WRITE) ? CMD_WRITE : CMD_READ;
              row_c  = rq.row;
              col_c  = rq.column;
              data_c = (rq.req_type == REQ_WRITE) ? rq.data : '0;
            end
          end else if (bus.req_valid && ras_zero) begin
            offer = 1'b1;
            cmd_c = CMD_PRECHARGE;
          end
        end
        PRE_WAIT: if (wait_zero) state_nxt = CLOSED;
        default: state_nxt = CLOSED;
      endcase
    end
    fire   = offer && bus.cmd_ready;
    is_col = (cmd_c == CMD_READ) || (cmd_c == CMD_WRITE);
    if (fire && cmd_c == CMD_ACTIVATE)  state_nxt = (T_RCD > 1) ? ACT_WAIT : OPEN;
    if (fire && cmd_c == CMD_PRECHARGE) state_nxt = (T_RP > 1) ? PRE_WAIT : CLOSED;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= CLOSED;
      row_open_q <= 1'b0;
      open_row_q <= '0;
    end else begin
      state <= state_nxt;
      if (fire && cmd_c == CMD_ACTIVATE) begin
        row_open_q <= 1'b1;
        open_row_q <= row_c;
      end else if (fire && cmd_c == CMD_PRECHARGE) begin
        row_open_q <= 1'b0;
      end
    end
  end

  ddr_bank_timer u_wait_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (fire && (cmd_c == CMD_ACTIVATE || cmd_c == CMD_PRECHARGE)),
    .load_val ((cmd_c == CMD_ACTIVATE) ? RCD_LOAD : RP_LOAD),
    .zero     (wait_zero)
  );

  ddr_bank_timer u_ras_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (fire && cmd_c == CMD_ACTIVATE),
    .load_val (RAS_LOAD),
    .zero     (ras_zero)
  );

  ddr_bank_timer u_ccd_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (fire && is_col),
    .load_val (CCD_LOAD),
    .zero     (ccd_zero)
  );

`ifdef BANK_IDLE_PRE_EN
  localparam logic [7:0] IDLE_LIMIT = 8'(IDLE_TIMEOUT);

  logic [7:0] idle_cnt;
  logic       pre_held;

  // Once the idle precharge is on the bus it stays offered even if a request arrives.
  assign idle_pre = pre_held || (!bus.req_valid && idle_cnt == IDLE_LIMIT && ras_zero);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt <= '0;
      pre_held <= 1'b0;
    end else if (state != OPEN || fire) begin
      idle_cnt <= '0;
      pre_held <= 1'b0;
    end else begin
      pre_held <= idle_pre;
      if (bus.req_valid && !idle_pre) idle_cnt <= '0;
      else if (idle_cnt != IDLE_LIMIT) idle_cnt <= idle_cnt + 8'd1;
    end
  end
`else
  assign idle_pre = 1'b0;
`endif

  assign bus.cmd_valid = offer;
  assign bus.cmd       = cmd_c;
  assign bus.cmd_row   = row_c;
  assign bus.cmd_col   = col_c;
  assign bus.cmd_data  = data_c;
  assign bus.req_ready = fire && is_col;
  assign bus.row_open  = row_open_q;
  assign bus.open_row  = open_row_q;

endmodule

// File: tb/tb_bank_cmd_scheduler.sv
// Directed bench for bank_cmd_scheduler (T_RCD=4, T_RP=4, T_RAS=8, T_CCD=2).
module tb_bank_cmd_scheduler;
  import bank_cmd_scheduler_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   busy;

  bank_cmd_scheduler_if bus_if ();

  bank_cmd_scheduler #(
    .T_RCD        (4),
    .T_RP         (4),
    .T_RAS        (8),
    .T_CCD        (2),
    .IDLE_TIMEOUT (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic v, input req_type_t t, input logic [15:0] row,
                         input logic [9:0] col, input logic [31:0] data);
    bus_if.req_valid = v;
    bus_if.req       = '{req_type: t, data: data, row: row, column: col};
  endtask

  task automatic expect_cmd(input string tag, input command_t c, input logic [15:0] row,
                            input logic [9:0] col, input logic [31:0] data, input logic rr);
    check({tag, ".valid"}, 64'(bus_if.cmd_valid), 64'(1));
    check({tag, ".cmd"},   64'(bus_if.cmd), 64'(c));
    check({tag, ".row"},   64'(bus_if.cmd_row), 64'(row));
    check({tag, ".col"},   64'(bus_if.cmd_col), 64'(col));
    check({tag, ".data"},  64'(bus_if.cmd_data), 64'(data));
    check({tag, ".rdy"},   64'(bus_if.req_ready), 64'(rr));
  endtask

  task automatic expect_quiet(input string tag);
    check({tag, ".valid"}, 64'(bus_if.cmd_valid), 64'(0));
    check({tag, ".cmd"},   64'(bus_if.cmd), 64'(CMD_NONE));
    check({tag, ".rdy"},   64'(bus_if.req_ready), 64'(0));
  endtask

  task automatic expect_reset(input string tag);
    expect_quiet(tag);
    check({tag, ".row"},      64'(bus_if.cmd_row), 64'(0));
    check({tag, ".col"},      64'(bus_if.cmd_col), 64'(0));
    check({tag, ".data"},     64'(bus_if.cmd_data), 64'(0));
    check({tag, ".row_open"}, 64'(bus_if.row_open), 64'(0));
    check({tag, ".open_row"}, 64'(bus_if.open_row), 64'(0));
  endtask

  // Holds reset for a cycle, presents the request, releases reset: caller is in cycle 0.
  task automatic start_seq(input req_type_t t, input logic [15:0] row, input logic [9:0] col);
    rst = 1'b1;
    set_req(1'b0, REQ_READ, '0, '0, '0);
    step();
    set_req(1'b1, t, row, col, '0);
    step();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    set_req(1'b0, REQ_READ, '0, '0, '0);
    bus_if.cmd_ready = 1'b1;

    // Test 1: reset values (even with a request pending), then read from closed bank
    step();
    set_req(1'b1, REQ_READ, 16'h0012, 10'h005, '0);
    #1;
    expect_reset("t1.reset");
    step();
    rst = 1'b0;
    #1;
    expect_cmd("t1.act", CMD_ACTIVATE, 16'h0012, 10'h0, 32'h0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      step(); #1;
      expect_quiet("t1.trcd");
    end
    step(); #1;
    expect_cmd("t1.rd", CMD_READ, 16'h0012, 10'h005, 32'h0, 1'b1);
    check("t1.row_open", 64'(bus_if.row_open), 64'(1));
    check("t1.open_row", 64'(bus_if.open_row), 64'h0012);

    // Test 2: row hits spaced by tCCD
    step();
    set_req(1'b1, REQ_WRITE, 16'h0012, 10'h010, 32'hDEADBEEF);
    #1;
    expect_quiet("t2.tccd_wr");
    step(); #1;
    expect_cmd("t2.wr", CMD_WRITE, 16'h0012, 10'h010, 32'hDEADBEEF, 1'b1);
    step();
    set_req(1'b1, REQ_READ, 16'h0012, 10'h011, 32'h0);
    #1;
    expect_quiet("t2.tccd_rd");
    step(); #1;
    expect_cmd("t2.rd", CMD_READ, 16'h0012, 10'h011, 32'h0, 1'b1);
    step();
    set_req(1'b0, REQ_READ, '0, '0, '0);

    // Test 3: row miss -> precharge at 8, activate at 12, column at 16
    start_seq(REQ_READ, 16'h0012, 10'h001);
    expect_cmd("t3.act0", CMD_ACTIVATE, 16'h0012, 10'h0, 32'h0, 1'b0);
    for (int i = 1; i <= 4; i++) step();
    #1;
    expect_cmd("t3.rd0", CMD_READ, 16'h0012, 10'h001, 32'h0, 1'b1);
    step();
    set_req(1'b1, REQ_READ, 16'h0034, 10'h002, '0);
    #1;
    expect_quiet("t3.c5");
    step(); #1; expect_quiet("t3.c6");
    step(); #1; expect_quiet("t3.c7");
    step(); #1;
    expect_cmd("t3.pre", CMD_PRECHARGE, 16'h0, 10'h0, 32'h0, 1'b0);
    for (int i = 9; i <= 11; i++) begin
      step(); #1;
      expect_quiet("t3.trp");
    end
    check("t3.closed", 64'(bus_if.row_open), 64'(0));
    step(); #1;
    expect_cmd("t3.act1", CMD_ACTIVATE, 16'h0034, 10'h0, 32'h0, 1'b0);
    for (int i = 13; i <= 15; i++) begin
      step(); #1;
      expect_quiet("t3.trcd");
    end
    step(); #1;
    expect_cmd("t3.rd1", CMD_READ, 16'h0034, 10'h002, 32'h0, 1'b1);
    check("t3.open_row", 64'(bus_if.open_row), 64'h0034);

    // Test 4: arbiter backpressure on activate for cycles 0-4
    bus_if.cmd_ready = 1'b0;
    start_seq(REQ_READ, 16'h0055, 10'h007);
    for (int i = 0; i <= 4; i++) begin
      expect_cmd("t4.hold", CMD_ACTIVATE, 16'h0055, 10'h0, 32'h0, 1'b0);
      check("t4.row_open", 64'(bus_if.row_open), 64'(0));
      step();
      #1;
    end
    bus_if.cmd_ready = 1'b1;
    #1;
    expect_cmd("t4.act", CMD_ACTIVATE, 16'h0055, 10'h0, 32'h0, 1'b0);
    for (int i = 6; i <= 8; i++) begin
      step(); #1;
      expect_quiet("t4.trcd");
    end
    step(); #1;
    expect_cmd("t4.rd", CMD_READ, 16'h0055, 10'h007, 32'h0, 1'b1);

    // Test 5: reset in ACT_WAIT, then the same request re-sequences
    start_seq(REQ_READ, 16'h0066, 10'h009);
    expect_cmd("t5.act0", CMD_ACTIVATE, 16'h0066, 10'h0, 32'h0, 1'b0);
    step();
    check("t5.opened", 64'(bus_if.row_open), 64'(1));
    rst = 1'b1;
    #1;
    expect_reset("t5.reset");
    step();
    rst = 1'b0;
    #1;
    expect_cmd("t5.act1", CMD_ACTIVATE, 16'h0066, 10'h0, 32'h0, 1'b0);
    for (int i = 1; i <= 4; i++) step();
    #1;
    expect_cmd("t5.rd", CMD_READ, 16'h0066, 10'h009, 32'h0, 1'b1);

    // Test 6: idle behaviour with the row left open
    step();
    set_req(1'b0, REQ_READ, '0, '0, '0);
    #1;
    busy = 0;
`ifdef BANK_IDLE_PRE_EN
    for (int i = 0; i < 16; i++) begin
      if (bus_if.cmd_valid) busy++;
      step(); #1;
    end
    check("t6.quiet_before", 64'(busy), 64'(0));
    expect_cmd("t6.idle_pre", CMD_PRECHARGE, 16'h0, 10'h0, 32'h0, 1'b0);
    step(); #1;
    check("t6.closed", 64'(bus_if.row_open), 64'(0));
`else
    for (int i = 0; i < 100; i++) begin
      if (bus_if.cmd_valid) busy++;
      step(); #1;
    end
    check("t6.no_cmd", 64'(busy), 64'(0));
    check("t6.still_open", 64'(bus_if.row_open), 64'(1));
    check("t6.open_row", 64'(bus_if.open_row), 64'h0066);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
